uart_buffered_tx: RTL
=====================

// Module: uart_buffered_tx
// PURPOSE
//  Buffered 8N1 UART transmitter: the send side of the board's UART link (Basys-3, 100 MHz Clk).
//  Bytes are pushed in over a valid/ready handshake into a small FIFO, then serialized LSB-first on Tx.
//  Drives the host-facing Tx pin and feeds the loopback/LED/SSD designs' echo path.
// PARAMETERS
//  ClocksPerBit  10417  Clk cycles per UART bit (100 MHz / 9600 baud)
//  FifoDepth     16     FIFO entries; power of two, >= 2
//  FifoAddrW     4      log2(FifoDepth)
// PORTS
//  Clk        in   1            system clock, all logic on rising edge
//  Rst        in   1            synchronous, active-high reset
//  En         in   1            1 = may start new frames; 0 = hold queued bytes
//  DataIn     in   8            byte to queue
//  DataValid  in   1            DataIn valid this cycle
//  DataReady  out  1            FIFO can accept; push = DataValid & DataReady
//  Tx         out  1            serial line, idle high
//  TxBusy     out  1            1 while a frame (start..stop) is on the line
//  TxDone     out  1            1-cycle pulse on last Clk of stop bit
//  FifoCount  out  FifoAddrW+1  bytes currently queued (0..FifoDepth)
// BEHAVIOUR
//  Reset (Rst=1 on an edge): Tx=1, TxBusy=0, TxDone=0, FifoCount=0, DataReady=1, state IDLE.
//   Rst mid-frame aborts it: Tx=1 from the next cycle, FIFO contents discarded.
//  DataReady = (FifoCount != FifoDepth), combinational from registered count. Push when full impossible.
//   Push and pop in same cycle: count unchanged; pointers wrap modulo FifoDepth.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: Tx=1. If En & FifoCount!=0: pop head into shift reg, go START next cycle.
//   START: Tx=0 for ClocksPerBit cycles. DATA: bits 0..7 LSB first, ClocksPerBit each.
//   STOP: Tx=1 for ClocksPerBit cycles; TxDone=1 on its final cycle; next state IDLE.
//  Bit timer counts 0..ClocksPerBit-1, resets at each bit boundary; bit index 0..7.
//  TxBusy=1 in every non-IDLE state. Frame = 10*ClocksPerBit cycles (11 with parity).
//  Back-to-back: exactly one IDLE cycle (Tx=1) between STOP end and next START.
//  En deassert mid-frame: current frame completes; no new pop until En=1.
//  DataIn/En changes never disturb a frame in flight (data held in shift reg).
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state after bit 7, Tx = even parity (XOR of 8 data bits),
//   ClocksPerBit long; frame becomes 8E1.
//  Undefined: no PARITY state, DATA -> STOP directly; 8N1.
// STRUCTURE
//  Package uart_pkg: state encoding constants (IDLE/START/DATA/PARITY/STOP), default
//   ClocksPerBit for 100 MHz/9600, frame bit counts.
//  One sub-module: uart_sync_fifo (Clk, Rst, push/pop, DataIn/DataOut, Full, Empty, Count).
//  Top holds FSM, bit timer, bit index, shift register.
// TESTING
//  1 byte 0x61, En=1: Tx = 0,1,0,0,0,0,1,1,0,1 each 10417 Clk; TxDone pulses once; TxBusy high 104170 cycles.
//  Push 0x55,0xA3 back-to-back: two frames, exactly 1 idle Clk between; FifoCount 2->1->0.
//  En=0, push 16 bytes: Tx stays 1, FifoCount=16, DataReady=0; 17th push ignored; En=1 sends all 16 in order.
//  Rst pulsed during bit 4 of 0x0F: Tx=1 next cycle, FifoCount=0, TxBusy=0, no TxDone.
//  Push during full with simultaneous pop (En=1, IDLE pop cycle): count stays 16 only if DataReady was 1; no data lost/duplicated.
//  UART_TX_PARITY_EN, byte 0x61: parity bit = 1 after bit 7; frame 11*10417 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// default bit timing for a 100 MHz clock at 9600 baud, and frame sizes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int CLOCKS_PER_BIT_DEFAULT = 10417;
  localparam int DATA_BITS              = 8;
  localparam int FRAME_BITS_8N1         = 10;
  localparam int FRAME_BITS_8E1         = 11;

  // Even parity over one data byte: 1 when the byte holds an odd number of ones.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous single-clock FIFO feeding the UART transmitter.
// Push is ignored when full, pop is ignored when empty; simultaneous push and
// pop leave the count unchanged. Pointers wrap naturally (Depth is a power of two).
module uart_sync_fifo #(
  parameter int Depth = 16,
  parameter int AddrW = 4,
  parameter int DataW = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Push,
  input  logic             Pop,
  input  logic [DataW-1:0] DataIn,
  output logic [DataW-1:0] DataOut,
  output logic             Full,
  output logic             Empty,
  output logic [AddrW:0]   Count
);

  localparam logic [AddrW:0] FullCount = (AddrW+1)'(Depth);

  logic [DataW-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign Full    = (count_q == FullCount);
  assign Empty   = (count_q == '0);
  assign Count   = count_q;
  assign DataOut = mem_q[rd_ptr_q];
  assign do_push = Push & ~Full;
  assign do_pop  = Pop & ~Empty;

  // Next-state for pointers and occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Control registers; reset empties the FIFO.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since the count gates reads.
  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= DataIn;
  end

endmodule

// File: rtl/uart_buffered_tx.sv
// Buffered UART transmitter: bytes enter a FIFO over a valid/ready handshake
// and are serialized LSB-first as 8N1 frames on Tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7 (8E1).
module uart_buffered_tx
  import uart_pkg::*;
#(
  parameter int ClocksPerBit = CLOCKS_PER_BIT_DEFAULT,
  parameter int FifoDepth    = 16,
  parameter int FifoAddrW    = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 En,
  input  logic [7:0]           DataIn,
  input  logic                 DataValid,
  output logic                 DataReady,
  output logic                 Tx,
  output logic                 TxBusy,
  output logic                 TxDone,
  output logic [FifoAddrW:0]   FifoCount
);

  localparam int TimerW = (ClocksPerBit > 2) ? $clog2(ClocksPerBit) : 1;
  localparam logic [TimerW-1:0] LastTick    = TimerW'(ClocksPerBit - 1);
  localparam logic [TimerW-1:0] PreLastTick = TimerW'(ClocksPerBit - 2);

  tx_state_e         state_q;
  logic [TimerW-1:0] timer_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              tx_q, busy_q, done_q;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [7:0]        fifo_data;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  uart_sync_fifo #(
    .Depth (FifoDepth),
    .AddrW (FifoAddrW),
    .DataW (8)
  ) u_fifo (
    .Clk     (Clk),
    .Rst     (Rst),
    .Push    (DataValid),
    .Pop     (fifo_pop),
    .DataIn  (DataIn),
    .DataOut (fifo_data),
    .Full    (fifo_full),
    .Empty   (fifo_empty),
    .Count   (FifoCount)
  );

  assign DataReady = ~fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) & En & ~fifo_empty;
  assign bit_end   = (timer_q == LastTick);
  assign Tx        = tx_q;
  assign TxBusy    = busy_q;
  assign TxDone    = done_q;

  // Frame FSM with bit timer, bit index and registered line outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          tx_q      <= 1'b1;
          busy_q    <= 1'b0;
          timer_q   <= '0;
          bit_idx_q <= '0;
          if (fifo_pop) begin
            state_q <= ST_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            state_q   <= ST_DATA;
            tx_q      <= shift_q[0];
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            timer_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= ST_PARITY;
              tx_q    <= parity_q;
`else
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            timer_q <= '0;
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_STOP: begin
          // Raise TxDone one tick early so the registered pulse lands on the last stop cycle.
          if (timer_q == PreLastTick) done_q <= 1'b1;
          if (bit_end) begin
            timer_q <= '0;
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Shift register: loaded on pop, shifted right at each data-bit boundary.
  always_ff @(posedge Clk) begin
    if (fifo_pop) begin
      shift_q <= fifo_data;
    end else if (state_q == ST_DATA && bit_end) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the frame's byte, captured with the data on pop.
  always_ff @(posedge Clk) begin
    if (fifo_pop) parity_q <= even_parity(fifo_data);
  end
`endif

endmodule
